// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS32 pipeline constants and the interlock state type
package mips_pkg;
    localparam int AW = 5;
    localparam int NREG = 32;
    localparam int WB_DIST_DEFAULT = 3;
    localparam logic [5:0] OP_HLT = 6'h3f;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage request and interlock response bundle
interface hazard_scoreboard_if #(
    parameter int AW   = mips_pkg::AW,
    parameter int NREG = mips_pkg::NREG
);
    import mips_pkg::*;

    logic            id_valid;
    logic [AW-1:0]   id_rs;
    logic [AW-1:0]   id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic            id_wr;
    logic [AW-1:0]   id_rd;
    logic            id_is_hlt;
    logic            flush;
    logic            stall;
    logic            issue;
    logic [NREG-1:0] busy_mask;
    state_t          state;
    logic            halted;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_is_hlt, flush,
        input  stall, issue, busy_mask, state, halted
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_rd, id_is_hlt, flush,
        output stall, issue, busy_mask, state, halted
    );
endinterface

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - saturating down-counter with a load that wins over decrement
module sb_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register write-pending scoreboard, ID stall and HLT drain sequencing
module hazard_scoreboard #(
    parameter int NREG    = mips_pkg::NREG,
    parameter int AW      = mips_pkg::AW,
    parameter int WB_DIST = mips_pkg::WB_DIST_DEFAULT,
    parameter int CW      = 3
) (
    input  logic            clk1,
    input  logic            rst,
    hazard_scoreboard_if.slave sb
);
    import mips_pkg::*;

    localparam logic [CW-1:0] LOAD_VAL = CW'(WB_DIST);

    logic [NREG-1:0] busy;
    logic            rs_haz;
    logic            rt_haz;
    logic            hazard;
    logic            issue_w;
    state_t          state_q;
    state_t          state_d;

    // R0 has no counter, so it can never report a pending write.
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_reg
        logic [CW-1:0] cnt;
        logic          load;

        assign load = issue_w & sb.id_wr & (sb.id_rd == AW'(r));

        sb_counter #(.CW(CW)) u_cnt (
            .clk      (clk1),
            .rst      (rst),
            .load     (load),
            .load_val (LOAD_VAL),
            .cnt      (cnt)
        );

        assign busy[r] = (cnt != '0);
    end

    assign rs_haz  = sb.id_use_rs & (sb.id_rs != '0) & busy[sb.id_rs];
    assign rt_haz  = sb.id_use_rt & (sb.id_rt != '0) & busy[sb.id_rt];
    assign hazard  = rs_haz | rt_haz;
    assign issue_w = sb.id_valid & (state_q == RUN) & ~hazard & ~sb.flush;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain completion looks at registered counters, so HALTED lands one cycle after the last write clears.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (issue_w & sb.id_is_hlt) state_d = DRAIN;
            DRAIN:   if (busy == '0) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    assign sb.stall     = sb.id_valid & ((state_q != RUN) | hazard);
    assign sb.issue     = issue_w;
    assign sb.busy_mask = busy;
    assign sb.state     = state_q;
    assign sb.halted    = (state_q == HALTED);
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed checks of hazard_scoreboard against a timeline model
module tb_hazard_scoreboard;
    import mips_pkg::*;

    localparam int WB = 3;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;
    always #5 clk1 = ~clk1;

    hazard_scoreboard_if #(.AW(5), .NREG(32)) sb ();

    hazard_scoreboard #(.NREG(32), .AW(5), .WB_DIST(WB), .CW(3)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .sb   (sb)
    );

    int checks = 0;
    int passed = 0;

    // Model: the cycle at which each register's pending write becomes readable.
    int ready [32];
    int cyc = 0;
    int mst = 0;

    logic        obs_stall, obs_issue, obs_halted;
    logic [31:0] obs_mask;
    logic [1:0]  obs_state;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        mst = 0;
    endtask

    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit wr, input int rd, input bit hlt, input bit fl);
        logic [31:0] mmask;
        bit haz, mstall, missue;
        sb.id_valid = v;  sb.id_rs = rs[4:0]; sb.id_rt = rt[4:0];
        sb.id_use_rs = urs; sb.id_use_rt = urt; sb.id_wr = wr; sb.id_rd = rd[4:0];
        sb.id_is_hlt = hlt; sb.flush = fl;
        #1;
        mmask = '0;
        for (int r = 1; r < 32; r++) if (cyc < ready[r]) mmask[r] = 1'b1;
        haz    = (urs && rs != 0 && mmask[rs]) || (urt && rt != 0 && mmask[rt]);
        mstall = v && (mst != 0 || haz);
        missue = v && mst == 0 && !haz && !fl;
        obs_stall = sb.stall; obs_issue = sb.issue; obs_mask = sb.busy_mask;
        obs_state = sb.state; obs_halted = sb.halted;
        chk("stall",     {31'd0, obs_stall}, {31'd0, mstall});
        chk("issue",     {31'd0, obs_issue}, {31'd0, missue});
        chk("busy_mask", obs_mask, mmask);
        chk("state",     {30'd0, obs_state}, mst);
        chk("halted",    {31'd0, obs_halted}, {31'd0, mst == 2});
        @(posedge clk1);
        if (missue && wr && rd != 0) ready[rd] = cyc + WB + 1;
        if (mst == 0 && missue && hlt) mst = 1;
        else if (mst == 1 && mmask == '0) mst = 2;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_mask",   sb.busy_mask, 32'd0);
        chk("rst_state",  {30'd0, sb.state}, 32'd0);
        chk("rst_halted", {31'd0, sb.halted}, 32'd0);
        model_clear();
        @(posedge clk1);
        cyc++;
        #1;
        rst = 1'b0;
    endtask

    // Consumer of rs=src repeatedly presented until it issues; returns stall count.
    task automatic consume(input int src, output int stalls, output int busy_cycles);
        stalls = 0; busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, src, 2, 1, 1, 1, 4, 0, 0);
            if (obs_mask[src]) busy_cycles++;
            if (obs_issue) break;
            if (obs_stall) stalls++;
        end
    endtask

    initial begin
        int st, bc, t_clear, t_halt, late_issue;
        sb.id_valid = 0; sb.id_rs = 0; sb.id_rt = 0; sb.id_use_rs = 0; sb.id_use_rt = 0;
        sb.id_wr = 0; sb.id_rd = 0; sb.id_is_hlt = 0; sb.flush = 0;
        model_clear();
        #2;
        do_reset();

        // No prior writes: reader issues immediately.
        step(1, 1, 2, 1, 1, 0, 0, 0, 0);
        chk("lit_idle_stall", {31'd0, obs_stall}, 32'd0);
        chk("lit_idle_issue", {31'd0, obs_issue}, 32'd1);
        chk("lit_idle_mask",  obs_mask, 32'd0);
        idle(2);

        // Back-to-back RAW on R1.
        step(1, 0, 0, 1, 0, 1, 1, 0, 0);
        consume(1, st, bc);
        chk("lit_raw1_stalls", st, 32'd3);
        chk("lit_raw1_busy",   bc, 32'd3);
        idle(5);

        // One instruction between producer and consumer.
        step(1, 0, 0, 1, 0, 1, 5, 0, 0);
        step(1, 9, 10, 1, 1, 0, 0, 0, 0);
        consume(5, st, bc);
        chk("lit_raw_k2_stalls", st, 32'd2);
        idle(5);

        // R0 is never busy.
        step(1, 0, 0, 1, 0, 1, 0, 0, 0);
        consume(0, st, bc);
        chk("lit_r0_stalls", st, 32'd0);
        idle(5);

        // WAW on R3: second write reloads, reader waits for it.
        step(1, 0, 0, 0, 0, 1, 3, 0, 0);
        step(1, 9, 10, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 3, 0, 0);
        consume(3, st, bc);
        chk("lit_waw_stalls", st, 32'd3);
        idle(5);

        // Write R7 then HLT; drain and halt.
        step(1, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        t_clear = -1; t_halt = -1; late_issue = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 8, 9, 1, 1, 1, 10, 0, 0);
            if (i == 0) chk("lit_drain_state", {30'd0, obs_state}, 32'd1);
            if (obs_issue) late_issue++;
            if (t_clear < 0 && obs_mask == 32'd0) t_clear = i;
            if (t_halt < 0 && obs_halted) t_halt = i;
        end
        chk("lit_halt_delay", t_halt - t_clear, 32'd1);
        chk("lit_after_hlt_issue", late_issue, 32'd0);
        chk("lit_halted_stall", {31'd0, obs_stall}, 32'd1);
        do_reset();

        // HLT squashed by flush stays in RUN.
        step(1, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("lit_hlt_flush_issue", {31'd0, obs_issue}, 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_hlt_flush_state", {30'd0, obs_state}, 32'd0);

        // Reset while draining.
        step(1, 0, 0, 0, 0, 1, 7, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_pre_rst_state", {30'd0, obs_state}, 32'd1);
        do_reset();

        // Randomized traffic on a small register window to provoke hazards.
        for (int i = 0; i < 1500; i++) begin
            bit hlt;
            hlt = ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1),
                 hlt ? 1'b0 : 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                 hlt, $urandom_range(0, 7) == 0);
            if ((mst == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0)
                do_reset();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-hazard interlock for the 5-stage MIPS32 pipeline (IF, ID, EX, MEM, WB). It tracks every register with an outstanding write and stalls the instruction in ID until its source operands are written back. This removes the need for dummy-instruction padding between dependent instructions. It also sequences the halt: after HLT issues, it drains the pipeline and then asserts `halted`.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; R0 is hard-wired zero.
- `AW`, 5: register index width.
- `WB_DIST`, 3: cycles between issue from ID and the write-back becoming readable in ID; legal range 1..7.
- `CW`, 3: counter width; must satisfy `WB_DIST` < 2^`CW`.

Ports:
- `clk1`, in, 1: single pipeline clock. All state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `id_valid`, in, 1: a valid instruction is present in ID.
- `id_rs`, in, `AW`: first source register index.
- `id_rt`, in, `AW`: second source register index.
- `id_use_rs`, in, 1: the instruction reads `id_rs`.
- `id_use_rt`, in, 1: the instruction reads `id_rt`.
- `id_wr`, in, 1: the instruction writes a register.
- `id_rd`, in, `AW`: destination register (rt for immediate/load forms, decoded upstream).
- `id_is_hlt`, in, 1: the instruction is HLT (opcode 6'h3f).
- `flush`, in, 1: a taken branch squashes the instruction in ID this cycle.
- `stall`, out, 1: hold IF/ID this cycle.
- `issue`, out, 1: the ID instruction advances to EX this cycle.
- `busy_mask`, out, `NREG`: bit r set when register r has a pending write; bit 0 is always 0.
- `state`, out, 2: RUN=0, DRAIN=1, HALTED=2.
- `halted`, out, 1: pipeline drained after HLT.

## Operation
- Each register r = 1..`NREG`-1 has a `CW`-bit down-counter `cnt[r]`.
- `busy_mask[r]` = (`cnt[r]` != 0).
- Hazard = (`id_use_rs` & `id_rs`!=0 & busy[`id_rs`]) | (`id_use_rt` & `id_rt`!=0 & busy[`id_rt`]).
- `stall` = `id_valid` & ((state==RUN & hazard) | state!=RUN).
- `issue` = `id_valid` & state==RUN & ~hazard & ~`flush`.
- On `issue` with `id_wr` and `id_rd`!=0: `cnt[id_rd]` loads `WB_DIST`.
- Every other nonzero counter decrements by 1 per cycle and saturates at 0.
- If a load and a decrement target the same register in the same cycle, the load wins. This covers WAW.
- A write to R0 never marks R0 busy.
- A squashed instruction (`flush`) never loads a counter. Instructions already issued still complete, so their counters keep running.
- State machine:
  - RUN → DRAIN on `issue` & `id_is_hlt`.
  - DRAIN → HALTED when `busy_mask`==0. This is evaluated on registered counters, so the transition takes 1 cycle after the last counter reaches 0.
  - HALTED is held until `rst`.
  - HLT together with `flush` does not issue; state stays RUN.
- An instruction arriving after HLT stalls, and never issues, in DRAIN and HALTED.

## Timing
- Outputs `stall` and `issue` are combinational from ID inputs and registered counters/state; there are no combinational paths through `cnt`.
- Counters and state update on the rising edge of `clk1`.
- A dependent consumer directly behind its producer sees exactly `WB_DIST` stall cycles, then issues.
- A consumer k instructions behind its producer (no stalls in between) sees max(0, `WB_DIST`-k+1) stall cycles.
- Reset values: all `cnt`=0, `busy_mask`=0, state=RUN, `halted`=0. `stall`/`issue` follow inputs, with `stall`=0 when idle.
- Reset asserted mid-operation clears all pending writes and any DRAIN/HALTED state immediately (asynchronously).

## Structure
- Shared package `mips_pkg` holds:
  - register index width `AW`, `NREG`;
  - the state enum RUN/DRAIN/HALTED;
  - the HLT opcode constant 6'h3f;
  - default `WB_DIST`.
- Sub-module `sb_counter` implements one saturating down-counter with priority load. It is instantiated `NREG`-1 times by a generate loop; the top level holds the hazard compare and the FSM.

## Test plan
- Reset, then `id_valid`=1 reading R1/R2 with no prior writes → `stall`=0, `issue`=1, `busy_mask`=0.
- Issue ADDI R1 (wr R1), then next cycle ADD R4,R1,R2 → `stall`=1 for exactly 3 cycles (`WB_DIST`=3), `issue` on the 4th; `busy_mask[1]` set for 3 cycles.
- Issue a write to R5, then one unrelated instruction, then a reader of R5 → 2 stall cycles. A write to R0 followed by a reader of R0 → 0 stalls.
- Issue a write to R3; two cycles later issue another write to R3 → `cnt[3]` reloads to 3. A reader then stalls until the second write completes.
- Issue a write to R7, then HLT → state=DRAIN. `halted`=1 exactly one cycle after `busy_mask` becomes 0. A following valid instruction is held with `stall`=1 and `issue`=0.
- HLT in ID together with `flush`=1 → no issue, state stays RUN. Assert `rst` mid-DRAIN → `busy_mask`=0 and state=RUN immediately.
